// File: rtl/onehot_data_mux.sv
// One-hot select AND-OR data multiplexer with a registered copy of the result
// and a sticky monitor flag for illegal multi-hot selects.
module onehot_data_mux #(
  parameter int N_INPUTS = 2,
  parameter int W_INPUT  = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_INPUTS*W_INPUT-1:0]   in,
  input  logic [N_INPUTS-1:0]           sel,
  output logic [W_INPUT-1:0]            out,
  output logic [W_INPUT-1:0]            out_q,
  output logic                          sel_multi,
  output logic                          sel_err
);

  logic [W_INPUT-1:0] masked [N_INPUTS];
  logic [W_INPUT-1:0] mux_next;
  logic [W_INPUT-1:0] out_q_reg;
  logic               sel_err_reg;

  // Each channel is gated by its own select bit; no priority between channels.
  generate
    for (genvar gi = 0; gi < N_INPUTS; gi++) begin : g_mask
      assign masked[gi] = in[gi*W_INPUT +: W_INPUT] & {W_INPUT{sel[gi]}};
    end
  endgenerate

  always_comb begin
    mux_next = '0;
    for (int i = 0; i < N_INPUTS; i++) begin
      mux_next = mux_next | masked[i];
    end
  end

  assign out = mux_next;

  generate
    if (N_INPUTS == 1) begin : g_single
      assign sel_multi = 1'b0;
    end else begin : g_multi
      logic seen_one;
      logic multi_next;

      // Second set bit encountered means popcount >= 2.
      always_comb begin
        seen_one   = 1'b0;
        multi_next = 1'b0;
        for (int i = 0; i < N_INPUTS; i++) begin
          if (sel[i]) begin
            if (seen_one) begin
              multi_next = 1'b1;
            end
            seen_one = 1'b1;
          end
        end
      end

      assign sel_multi = multi_next;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q_reg   <= '0;
      sel_err_reg <= 1'b0;
    end else begin
      out_q_reg   <= mux_next;
      sel_err_reg <= sel_err_reg | sel_multi;
    end
  end

  assign out_q   = out_q_reg;
  assign sel_err = sel_err_reg;

endmodule

// File: tb/tb_onehot_data_mux.sv
// Directed bench for onehot_data_mux across four parameterisations sharing clk/rst_n.
module tb_onehot_data_mux;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic [63:0] in_a;
  logic [1:0]  sel_a;
  logic [31:0] out_a, out_q_a;
  logic        multi_a, err_a;

  logic [31:0] in_b;
  logic [3:0]  sel_b;
  logic [7:0]  out_b, out_q_b;
  logic        multi_b, err_b;

  logic [47:0] in_c;
  logic [2:0]  sel_c;
  logic [15:0] out_c, out_q_c;
  logic        multi_c, err_c;

  logic [3:0]  in_d;
  logic [0:0]  sel_d;
  logic [3:0]  out_d, out_q_d;
  logic        multi_d, err_d;

  onehot_data_mux #(.N_INPUTS(2), .W_INPUT(32)) u_a (
    .clk(clk), .rst_n(rst_n), .in(in_a), .sel(sel_a),
    .out(out_a), .out_q(out_q_a), .sel_multi(multi_a), .sel_err(err_a)
  );

  onehot_data_mux #(.N_INPUTS(4), .W_INPUT(8)) u_b (
    .clk(clk), .rst_n(rst_n), .in(in_b), .sel(sel_b),
    .out(out_b), .out_q(out_q_b), .sel_multi(multi_b), .sel_err(err_b)
  );

  onehot_data_mux #(.N_INPUTS(3), .W_INPUT(16)) u_c (
    .clk(clk), .rst_n(rst_n), .in(in_c), .sel(sel_c),
    .out(out_c), .out_q(out_q_c), .sel_multi(multi_c), .sel_err(err_c)
  );

  onehot_data_mux #(.N_INPUTS(1), .W_INPUT(4)) u_d (
    .clk(clk), .rst_n(rst_n), .in(in_d), .sel(sel_d),
    .out(out_d), .out_q(out_q_d), .sel_multi(multi_d), .sel_err(err_d)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  logic [15:0] ch [3];
  logic [15:0] exp_c;
  logic [15:0] prev_exp_c;

  initial begin
    rst_n = 1'b0;
    in_a = '0; sel_a = '0;
    in_b = '0; sel_b = '0;
    in_c = '0; sel_c = '0;
    in_d = '0; sel_d = '0;
    #2;
    check("rst_out_q_a", out_q_a, 32'h0);
    check("rst_err_a",   err_a,   1'b0);
    check("rst_out_q_b", out_q_b, 8'h0);
    check("rst_err_b",   err_b,   1'b0);
    check("rst_out_q_c", out_q_c, 16'h0);
    check("rst_err_d",   err_d,   1'b0);
    $display("txn reset: out_q_a=%h err_a=%b", out_q_a, err_a);
    @(negedge clk);
    rst_n = 1'b1;

    // N=2, W=32 single and empty selects
    @(negedge clk);
    in_a  = {32'hCAFEF00D, 32'h12345678};
    sel_a = 2'b01;
    #1;
    check("a_sel01_out",   out_a,   32'h12345678);
    check("a_sel01_multi", multi_a, 1'b0);
    @(posedge clk); #1;
    check("a_sel01_out_q", out_q_a, 32'h12345678);
    $display("txn A sel=01 out=%h out_q=%h", out_a, out_q_a);

    @(negedge clk);
    sel_a = 2'b10;
    #1;
    check("a_sel10_out", out_a, 32'hCAFEF00D);
    $display("txn A sel=10 out=%h", out_a);
    @(negedge clk);
    sel_a = 2'b00;
    #1;
    check("a_sel00_out", out_a, 32'h0);
    @(posedge clk); #1;
    check("a_sel00_out_q", out_q_a, 32'h0);
    check("a_sel00_err",   err_a,   1'b0);
    $display("txn A sel=00 out=%h err=%b", out_a, err_a);

    @(negedge clk);
    sel_a = 2'b11;
    #1;
    check("a_sel11_out",   out_a,   32'hDAFEF67D);
    check("a_sel11_multi", multi_a, 1'b1);
    @(posedge clk); #1;
    check("a_sel11_err",   err_a,   1'b1);
    $display("txn A sel=11 out=%h err=%b", out_a, err_a);

    // N=4, W=8 multi-hot and sticky error
    @(negedge clk);
    in_b  = {8'h80, 8'h40, 8'h20, 8'h01};
    sel_b = 4'b0101;
    #1;
    check("b_0101_out",   out_b,   8'h41);
    check("b_0101_multi", multi_b, 1'b1);
    check("b_0101_err_pre", err_b, 1'b0);
    @(posedge clk); #1;
    check("b_0101_err",   err_b,   1'b1);
    check("b_0101_out_q", out_q_b, 8'h41);
    $display("txn B sel=0101 out=%h err=%b", out_b, err_b);

    @(negedge clk);
    sel_b = 4'b0001;
    #1;
    check("b_0001_out",   out_b,   8'h01);
    check("b_0001_multi", multi_b, 1'b0);
    @(posedge clk); #1;
    check("b_0001_err_sticky", err_b, 1'b1);
    $display("txn B sel=0001 out=%h err=%b", out_b, err_b);

    @(negedge clk);
    sel_b = 4'b0011;
    #1;
    check("b_0011_out", out_b, 8'h21);
    @(posedge clk); #1;
    check("b_0011_out_q", out_q_b, 8'h21);
    $display("txn B sel=0011 out=%h out_q=%h", out_b, out_q_b);

    // Asynchronous reset between edges
    #2;
    rst_n = 1'b0;
    #1;
    check("b_arst_out_q", out_q_b, 8'h0);
    check("b_arst_err",   err_b,   1'b0);
    check("a_arst_err",   err_a,   1'b0);
    check("b_arst_out",   out_b,   8'h21);
    check("b_arst_multi", multi_b, 1'b1);
    sel_b = 4'b1000;
    #1;
    check("b_arst_out_follow",   out_b,   8'h80);
    check("b_arst_multi_follow", multi_b, 1'b0);
    $display("txn B async reset out_q=%h err=%b out=%h", out_q_b, err_b, out_b);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("b_rel_out_q", out_q_b, 8'h80);
    check("b_rel_err",   err_b,   1'b0);
    $display("txn B reset release out_q=%h", out_q_b);

    // N=3, W=16 random sweep against a reference channel pick
    prev_exp_c = '0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (k > 0) check("c_out_q", out_q_c, prev_exp_c);
      for (int j = 0; j < 3; j++) ch[j] = 16'($urandom);
      in_c = {ch[2], ch[1], ch[0]};
      case (k % 4)
        0: begin sel_c = 3'b001; exp_c = ch[0]; end
        1: begin sel_c = 3'b010; exp_c = ch[1]; end
        2: begin sel_c = 3'b100; exp_c = ch[2]; end
        default: begin sel_c = 3'b000; exp_c = 16'h0; end
      endcase
      #1;
      check("c_out",   out_c,   exp_c);
      check("c_multi", multi_c, 1'b0);
      prev_exp_c = exp_c;
      $display("txn C k=%0d sel=%b out=%h", k, sel_c, out_c);
    end
    @(posedge clk); #1;
    check("c_out_q_last", out_q_c, prev_exp_c);
    check("c_err_never",  err_c,   1'b0);

    // N=1, W=4 toggling select
    in_d = 4'hA;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      sel_d = 1'(k % 2);
      #1;
      check("d_out",   out_d,   (k % 2 == 1) ? 4'hA : 4'h0);
      check("d_multi", multi_d, 1'b0);
      @(posedge clk); #1;
      check("d_out_q", out_q_d, (k % 2 == 1) ? 4'hA : 4'h0);
      $display("txn D sel=%b out=%h out_q=%h", sel_d, out_d, out_q_d);
    end
    check("d_err", err_d, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
